si5340_reg_access: RTL and testbench

SI5340_REG_ACCESS -- requirements
Module: si5340_reg_access

---
 rtl/si5340_reg_access_pkg.sv | 26 ++
 rtl/si5340_reg_access_if.sv | 22 ++
 rtl/si5340_reg_access.sv | 171 +++++++++++++++++
 tb/tb_si5340_reg_access.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/si5340_reg_access_pkg.sv
// Shared types and constants for the Si5340 paged register access engine.
package si5340_reg_access_pkg;

  localparam logic [6:0] SLAVE_ADDR_DEF = 7'h74;
  localparam logic [7:0] PAGE_REG_ADDR  = 8'h01;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PG_SA,
    ST_PG_REG,
    ST_PG_DAT,
    ST_RG_SA,
    ST_RG_REG,
    ST_WR_DAT,
    ST_RD_SA,
    ST_RD_DAT,
    ST_ERR_STOP,
    ST_RSP
  } state_e;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } r_w_e;

endpackage

// File: rtl/si5340_reg_access_if.sv
// Command/response bundle between the register access engine and an I2C byte controller.
interface si5340_reg_access_if;
  logic       start_o;
  logic       stop_o;
  logic       read_o;
  logic       write_o;
  logic       ack_in_o;
  logic [7:0] din_o;
  logic       cmd_ack_i;
  logic       ack_out_i;
  logic [7:0] dout_i;

  modport master (
    output start_o, stop_o, read_o, write_o, ack_in_o, din_o,
    input  cmd_ack_i, ack_out_i, dout_i
  );

  modport slave (
    input  start_o, stop_o, read_o, write_o, ack_in_o, din_o,
    output cmd_ack_i, ack_out_i, dout_i
  );
endinterface

// File: rtl/si5340_reg_access.sv
// Paged register read/write engine for the Si5340: caches the current page and
// sequences byte-controller commands for page select, register write and register read.
module si5340_reg_access
  import si5340_reg_access_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = SLAVE_ADDR_DEF
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rd_i,
  input  logic [15:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_err_o,
  si5340_reg_access_if.master bc
);

  state_e      state_q, state_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  wdat_q, wdat_d;
  r_w_e        rw_q, rw_d;
  logic [7:0]  page_q, page_d;
  logic        page_vld_q, page_vld_d;
  logic        err_q, err_d;
  logic [7:0]  rdat_q, rdat_d;
  logic        rdy_q;
  logic        wr_byte;
  logic        accept;

  assign req_ready_o = rdy_q && (state_q == ST_IDLE);
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state_q == ST_RSP);
  assign rsp_err_o   = err_q && (state_q == ST_RSP);
  assign rsp_data_o  = rdat_q;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdat_q     <= '0;
      rw_q       <= RW_WRITE;
      page_q     <= '0;
      page_vld_q <= 1'b0;
      err_q      <= 1'b0;
      rdat_q     <= '0;
      rdy_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdat_q     <= wdat_d;
      rw_q       <= rw_d;
      page_q     <= page_d;
      page_vld_q <= page_vld_d;
      err_q      <= err_d;
      rdat_q     <= rdat_d;
      rdy_q      <= 1'b1;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wdat_d      = wdat_q;
    rw_d        = rw_q;
    page_d      = page_q;
    page_vld_d  = page_vld_q;
    err_d       = err_q;
    rdat_d      = rdat_q;
    wr_byte     = 1'b0;
    bc.start_o  = 1'b0;
    bc.stop_o   = 1'b0;
    bc.read_o   = 1'b0;
    bc.write_o  = 1'b0;
    bc.ack_in_o = 1'b0;
    bc.din_o    = '0;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = req_addr_i;
          wdat_d  = req_data_i;
          rw_d    = r_w_e'(req_rd_i);
          err_d   = 1'b0;
          state_d = (page_vld_q && (page_q == req_addr_i[15:8])) ? ST_RG_SA : ST_PG_SA;
        end
      end
      ST_PG_SA: begin
        wr_byte    = 1'b1;
        bc.start_o = 1'b1;
        bc.write_o = 1'b1;
        bc.din_o   = {SLAVE_ADDR, 1'b0};
        if (bc.cmd_ack_i) state_d = ST_PG_REG;
      end
      ST_PG_REG: begin
        wr_byte    = 1'b1;
        bc.write_o = 1'b1;
        bc.din_o   = PAGE_REG_ADDR;
        if (bc.cmd_ack_i) state_d = ST_PG_DAT;
      end
      ST_PG_DAT: begin
        wr_byte    = 1'b1;
        bc.write_o = 1'b1;
        bc.stop_o  = 1'b1;
        bc.din_o   = addr_q[15:8];
        if (bc.cmd_ack_i) begin
          page_d     = addr_q[15:8];
          page_vld_d = 1'b1;
          state_d    = ST_RG_SA;
        end
      end
      ST_RG_SA: begin
        wr_byte    = 1'b1;
        bc.start_o = 1'b1;
        bc.write_o = 1'b1;
        bc.din_o   = {SLAVE_ADDR, 1'b0};
        if (bc.cmd_ack_i) state_d = ST_RG_REG;
      end
      ST_RG_REG: begin
        wr_byte    = 1'b1;
        bc.write_o = 1'b1;
        bc.din_o   = addr_q[7:0];
        if (bc.cmd_ack_i) state_d = (rw_q == RW_READ) ? ST_RD_SA : ST_WR_DAT;
      end
      ST_WR_DAT: begin
        wr_byte    = 1'b1;
        bc.write_o = 1'b1;
        bc.stop_o  = 1'b1;
        bc.din_o   = wdat_q;
        if (bc.cmd_ack_i) state_d = ST_RSP;
      end
      ST_RD_SA: begin
        wr_byte    = 1'b1;
        bc.start_o = 1'b1;
        bc.write_o = 1'b1;
        bc.din_o   = {SLAVE_ADDR, 1'b1};
        if (bc.cmd_ack_i) state_d = ST_RD_DAT;
      end
      ST_RD_DAT: begin
        bc.read_o   = 1'b1;
        bc.stop_o   = 1'b1;
        bc.ack_in_o = 1'b1;
        if (bc.cmd_ack_i) begin
          rdat_d  = bc.dout_i;
          state_d = ST_RSP;
        end
      end
      ST_ERR_STOP: begin
        bc.stop_o = 1'b1;
        if (bc.cmd_ack_i) state_d = ST_RSP;
      end
      ST_RSP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A NACK on any written byte overrides the per-state transition, including the
    // page-cache update in PG_DAT, so the cache is never marked valid for an unacked page.
    if (wr_byte && bc.cmd_ack_i && bc.ack_out_i) begin
      state_d    = ST_ERR_STOP;
      page_vld_d = 1'b0;
      err_d      = 1'b1;
    end
  end

endmodule

// File: tb/tb_si5340_reg_access.sv
// Directed bench for si5340_reg_access with a byte-controller/Si5340 slave model.
module tb_si5340_reg_access;
  import si5340_reg_access_pkg::*;

  localparam logic [9:0] TK_S = 10'h100;
  localparam logic [9:0] TK_P = 10'h101;
  localparam logic [9:0] TK_R = 10'h200;

  logic        clk_i = 1'b0;
  logic        arstn_i = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic        req_rd_i = 1'b0;
  logic [15:0] req_addr_i = '0;
  logic [7:0]  req_data_i = '0;
  logic        rsp_valid_o;
  logic [7:0]  rsp_data_o;
  logic        rsp_err_o;

  si5340_reg_access_if bc ();

  si5340_reg_access #(.SLAVE_ADDR(7'h74)) dut (
    .clk_i       (clk_i),
    .arstn_i     (arstn_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rd_i    (req_rd_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .bc          (bc)
  );

  always #5 clk_i = ~clk_i;

  // Byte controller plus slave at 7'h74 with a page register at 0x01.
  logic [7:0]  mem [0:65535];
  logic [9:0]  bus_q [$];
  logic [3:0]  lat_q;
  logic [1:0]  ph_q;
  logic [7:0]  ptr_q;
  logic [7:0]  pg_q;
  logic        nack_addr = 1'b0;
  logic        cmd_any;
  int          rsp_cnt = 0;

  assign cmd_any = bc.start_o | bc.stop_o | bc.read_o | bc.write_o;

  always @(posedge clk_i) begin
    if (!arstn_i) begin
      bc.cmd_ack_i <= 1'b0;
      bc.ack_out_i <= 1'b0;
      bc.dout_i    <= '0;
      lat_q        <= '0;
      ph_q         <= '0;
    end else begin
      bc.cmd_ack_i <= 1'b0;
      if (cmd_any && !bc.cmd_ack_i) begin
        if (lat_q != 4'd3) begin
          lat_q <= lat_q + 4'd1;
        end else begin
          lat_q        <= '0;
          bc.cmd_ack_i <= 1'b1;
          bc.ack_out_i <= 1'b0;
          if (bc.start_o) bus_q.push_back(TK_S);
          if (bc.write_o) begin
            bus_q.push_back({2'b00, bc.din_o});
            if (bc.start_o || ph_q == 2'd0) begin
              bc.ack_out_i <= (bc.din_o[7:1] != 7'h74) || nack_addr;
              ph_q         <= 2'd1;
            end else if (ph_q == 2'd1) begin
              ptr_q <= bc.din_o;
              ph_q  <= 2'd2;
            end else begin
              if (ptr_q == 8'h01) pg_q <= bc.din_o;
              else mem[{pg_q, ptr_q}] <= bc.din_o;
              ptr_q <= ptr_q + 8'd1;
            end
          end
          if (bc.read_o) begin
            bc.dout_i <= mem[{pg_q, ptr_q}];
            bus_q.push_back(TK_R | {2'b00, mem[{pg_q, ptr_q}]});
            ptr_q <= ptr_q + 8'd1;
          end
          if (bc.stop_o) begin
            bus_q.push_back(TK_P);
            ph_q <= 2'd0;
          end
        end
      end else begin
        lat_q <= '0;
      end
    end
  end

  always @(posedge clk_i) if (rsp_valid_o) rsp_cnt <= rsp_cnt + 1;

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        nack;
    logic        exp_err;
    logic [7:0]  exp_data;
    int          base;
    int          n;
  } vec_t;

  vec_t       vecs [8];
  logic [9:0] exp_tok [$];
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input int b, input logic rd, input logic [15:0] a,
                         input logic [7:0] d, input logic nk, input logic ee, input logic [7:0] ed);
    vecs[i].rd = rd; vecs[i].addr = a; vecs[i].data = d; vecs[i].nack = nk;
    vecs[i].exp_err = ee; vecs[i].exp_data = ed;
    vecs[i].base = b; vecs[i].n = exp_tok.size() - b;
  endtask

  task automatic run_req(input int idx);
    int t;
    int r0;
    logic [9:0] got;
    bus_q.delete();
    nack_addr = vecs[idx].nack;
    r0 = rsp_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1;
    req_rd_i    = vecs[idx].rd;
    req_addr_i  = vecs[idx].addr;
    req_data_i  = vecs[idx].data;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk_i); t++; end
    chk($sformatf("v%0d_ready", idx), req_ready_o, 1);
    @(negedge clk_i);
    req_valid_i = 1'b0;
    req_rd_i    = ~vecs[idx].rd;
    req_addr_i  = ~vecs[idx].addr;
    req_data_i  = ~vecs[idx].data;
    t = 0;
    while (!rsp_valid_o && t < 400) begin @(negedge clk_i); t++; end
    chk($sformatf("v%0d_rsp_valid", idx), rsp_valid_o, 1);
    chk($sformatf("v%0d_rsp_err", idx), rsp_err_o, vecs[idx].exp_err);
    chk($sformatf("v%0d_rsp_data", idx), rsp_data_o, vecs[idx].exp_data);
    @(negedge clk_i);
    chk($sformatf("v%0d_pulse_end", idx), rsp_valid_o, 0);
    chk($sformatf("v%0d_ready_after_rsp", idx), req_ready_o, 1);
    chk($sformatf("v%0d_rsp_count", idx), rsp_cnt - r0, 1);
    chk($sformatf("v%0d_bus_len", idx), bus_q.size(), vecs[idx].n);
    for (int i = 0; i < vecs[idx].n; i++) begin
      got = (i < bus_q.size()) ? bus_q[i] : 10'h3FF;
      chk($sformatf("v%0d_bus%0d", idx, i), got, exp_tok[vecs[idx].base + i]);
    end
    nack_addr = 1'b0;
  endtask

  initial begin
    int b;
    int t;
    int r0;
    int n;
    int pgw;
    logic pr;

    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h001, 10'h00B, TK_P, TK_S, 10'h0E8, 10'h024, 10'h0C0, TK_P};
    set_vec(0, b, 1'b0, 16'h0B24, 8'hC0, 1'b0, 1'b0, 8'h00);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h025, 10'h000, TK_P};
    set_vec(1, b, 1'b0, 16'h0B25, 8'h00, 1'b0, 1'b0, 8'h00);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h024, TK_S, 10'h0E9, TK_R | 10'h0C0, TK_P};
    set_vec(2, b, 1'b1, 16'h0B24, 8'h00, 1'b0, 1'b0, 8'hC0);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, TK_P};
    set_vec(3, b, 1'b0, 16'h0B25, 8'h77, 1'b1, 1'b1, 8'hC0);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h001, 10'h00B, TK_P,
               TK_S, 10'h0E8, 10'h024, TK_S, 10'h0E9, TK_R | 10'h0C0, TK_P};
    set_vec(4, b, 1'b1, 16'h0B24, 8'h00, 1'b0, 1'b0, 8'hC0);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h001, 10'h012, TK_P, TK_S, 10'h0E8, 10'h034, 10'h05A, TK_P};
    set_vec(5, b, 1'b0, 16'h1234, 8'h5A, 1'b0, 1'b0, 8'hC0);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h034, TK_S, 10'h0E9, TK_R | 10'h05A, TK_P};
    set_vec(6, b, 1'b1, 16'h1234, 8'h00, 1'b0, 1'b0, 8'h5A);
    b = exp_tok.size();
    exp_tok = {exp_tok, TK_S, 10'h0E8, 10'h001, 10'h00B, TK_P,
               TK_S, 10'h0E8, 10'h024, TK_S, 10'h0E9, TK_R | 10'h0C0, TK_P};
    set_vec(7, b, 1'b1, 16'h0B24, 8'h00, 1'b0, 1'b0, 8'hC0);

    repeat (3) @(negedge clk_i);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_rsp_err", rsp_err_o, 0);
    chk("rst_rsp_data", rsp_data_o, 0);
    chk("rst_cmds", {bc.start_o, bc.stop_o, bc.read_o, bc.write_o, bc.ack_in_o}, 0);
    chk("rst_din", bc.din_o, 0);
    arstn_i = 1'b1;
    #1;
    chk("ready_before_edge", req_ready_o, 0);
    @(posedge clk_i);
    #1;
    chk("ready_first_edge", req_ready_o, 1);

    for (int i = 0; i < 7; i++) run_req(i);
    chk("mem_0B24", mem[16'h0B24], 8'hC0);
    chk("mem_0B25", mem[16'h0B25], 8'h00);
    chk("mem_1234", mem[16'h1234], 8'h5A);

    // Reset while the register-address byte is being sent.
    r0 = rsp_cnt;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_rd_i = 1'b0; req_addr_i = 16'h0B30; req_data_i = 8'h77;
    t = 0;
    while (!req_ready_o && t < 50) begin @(negedge clk_i); t++; end
    @(negedge clk_i);
    req_valid_i = 1'b0;
    t = 0;
    while (!(bc.write_o && !bc.start_o && bc.din_o == 8'h30) && t < 400) begin
      @(negedge clk_i); t++;
    end
    chk("rg_reg_reached", bc.din_o, 8'h30);
    #2 arstn_i = 1'b0;
    #1;
    chk("mid_rst_write", bc.write_o, 0);
    chk("mid_rst_din", bc.din_o, 0);
    chk("mid_rst_ready", req_ready_o, 0);
    chk("mid_rst_rsp_data", rsp_data_o, 0);
    repeat (2) @(negedge clk_i);
    arstn_i = 1'b1;
    repeat (5) @(negedge clk_i);
    chk("mid_rst_no_rsp", rsp_cnt - r0, 0);
    chk("mid_rst_no_write", mem[16'h0B30] === 8'h77, 0);
    run_req(7);

    // Three back-to-back writes with req_valid_i held high throughout.
    bus_q.delete();
    r0 = rsp_cnt;
    n = 0;
    @(negedge clk_i);
    req_valid_i = 1'b1; req_rd_i = 1'b0; req_addr_i = 16'h0C40; req_data_i = 8'hA1;
    pr = req_ready_o;
    t = 0;
    while (n < 3 && t < 1000) begin
      @(negedge clk_i); t++;
      if (pr) begin
        n++;
        if (n < 3) begin
          req_addr_i = 16'h0C40 + 16'(n);
          req_data_i = 8'hA1 + 8'(n);
        end else begin
          req_valid_i = 1'b0;
        end
      end
      pr = req_ready_o;
    end
    chk("b2b_accepts", n, 3);
    t = 0;
    while (rsp_cnt - r0 < 3 && t < 1000) begin @(negedge clk_i); t++; end
    repeat (4) @(negedge clk_i);
    chk("b2b_rsp_count", rsp_cnt - r0, 3);
    pgw = 0;
    foreach (bus_q[i]) if (bus_q[i] == 10'h001) pgw++;
    chk("b2b_page_writes", pgw, 1);
    chk("b2b_bus_len", bus_q.size(), 20);
    chk("mem_0C40", mem[16'h0C40], 8'hA1);
    chk("mem_0C41", mem[16'h0C41], 8'hA2);
    chk("mem_0C42", mem[16'h0C42], 8'hA3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

endmodule
